// File: rtl/ps2_dir_scheduler_if.sv
// rtl/ps2_dir_scheduler_if.sv - byte-input and command-handshake bundle for ps2_dir_scheduler
//
// Signals:
//   ps2_data        [7:0]  received PS/2 byte
//   ps2_key_pressed        one-cycle strobe, ps2_data valid this cycle
//   cmd_ack                processor accepts cmd_dir
//   cmd_valid              command pending
//   cmd_dir         [1:0]  direction: 0 up, 1 right, 2 down, 3 left
// Modports:
//   master - byte source and command consumer (receiver + processor side)
//   slave  - the scheduler
interface ps2_dir_scheduler_if;
   logic [7:0] ps2_data;
   logic       ps2_key_pressed;
   logic       cmd_ack;
   logic       cmd_valid;
   logic [1:0] cmd_dir;

   modport master (
      output ps2_data,
      output ps2_key_pressed,
      output cmd_ack,
      input  cmd_valid,
      input  cmd_dir
   );

   modport slave (
      input  ps2_data,
      input  ps2_key_pressed,
      input  cmd_ack,
      output cmd_valid,
      output cmd_dir
   );
endinterface

// File: rtl/ps2_dir_scheduler.sv
// rtl/ps2_dir_scheduler.sv - PS/2 arrow-key parser and paced direction command scheduler
//
// Ports:
//   clk           system clock
//   resetn        asynchronous active-low reset
//   bus           ps2_dir_scheduler_if.slave: PS/2 byte input, cmd valid/ack output
//   cur_dir [1:0] last acknowledged direction
//   held    [3:0] key-held bitmap, bit index = direction code
//   tick          one-cycle pulse per game step
//   protocol_err  one-cycle pulse on a prefix byte following a break prefix
module ps2_dir_scheduler #(
   parameter int TICK_CYCLES = 5000000,
   parameter int CNT_W       = 25
) (
   input  logic                 clk,
   input  logic                 resetn,
   ps2_dir_scheduler_if.slave   bus,
   output logic [1:0]           cur_dir,
   output logic [3:0]           held,
   output logic                 tick,
   output logic                 protocol_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             perr_q, perr_d;
   logic [3:0]       held_q, held_d;
   logic [3:0]       pending_q, pending_d;
   logic [1:0]       last_make_q, last_make_d;
   logic [1:0]       cur_dir_q, cur_dir_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [1:0]       cmd_dir_q, cmd_dir_d;

   logic       is_arrow;
   logic [1:0] arrow_dir;
   logic       is_e0;
   logic       is_f0;
   logic       do_make;
   logic       do_break;
   logic       eval;
   logic [3:0] cand;
   logic [1:0] sel;

   always_comb begin
      // Byte decode
      is_arrow  = 1'b1;
      arrow_dir = 2'd0;
      case (bus.ps2_data)
         8'h75:   arrow_dir = 2'd0;
         8'h74:   arrow_dir = 2'd1;
         8'h72:   arrow_dir = 2'd2;
         8'h6B:   arrow_dir = 2'd3;
         default: is_arrow  = 1'b0;
      endcase
      is_e0 = (bus.ps2_data == 8'hE0);
      is_f0 = (bus.ps2_data == 8'hF0);

      // Parser
      state_d  = state_q;
      do_make  = 1'b0;
      do_break = 1'b0;
      perr_d   = 1'b0;
      if (bus.ps2_key_pressed) begin
         case (state_q)
            ST_IDLE: begin
               if (is_e0)      state_d = ST_EXT;
               else if (is_f0) state_d = ST_BRK;
               else            do_make = is_arrow;
            end
            ST_EXT: begin
               if (is_f0)      state_d = ST_EXT_BRK;
               else if (is_e0) state_d = ST_EXT;
               else begin
                  do_make = is_arrow;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               // A second prefix after a break prefix is malformed.
               state_d = ST_IDLE;
               if (is_e0 || is_f0) perr_d   = 1'b1;
               else                do_break = is_arrow;
            end
         endcase
      end

      // Step counter
      tick_d = (cnt_q == CNT_LAST);
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;

      // Arbitration: candidates exclude the reverse of the current heading.
      eval = tick_q && !cmd_valid_q;
      cand = (pending_q | held_q) & ~(4'b0001 << (cur_dir_q ^ 2'd2));
      if (cand[last_make_q]) sel = last_make_q;
      else if (cand[0])      sel = 2'd0;
      else if (cand[1])      sel = 2'd1;
      else if (cand[2])      sel = 2'd2;
      else                   sel = 2'd3;

      cmd_valid_d = cmd_valid_q;
      cmd_dir_d   = cmd_dir_q;
      cur_dir_d   = cur_dir_q;
      if (cmd_valid_q && bus.cmd_ack) begin
         cmd_valid_d = 1'b0;
         cur_dir_d   = cmd_dir_q;
      end
      if (eval && (cand != 4'd0) && (sel != cur_dir_q)) begin
         cmd_valid_d = 1'b1;
         cmd_dir_d   = sel;
      end

      // A make arriving in the evaluation cycle lands after the clear,
      // so it counts toward the following step.
      pending_d   = eval ? 4'd0 : pending_q;
      held_d      = held_q;
      last_make_d = last_make_q;
      if (do_make) begin
         held_d[arrow_dir]    = 1'b1;
         pending_d[arrow_dir] = 1'b1;
         last_make_d          = arrow_dir;
      end
      if (do_break) held_d[arrow_dir] = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         perr_q      <= 1'b0;
         held_q      <= 4'd0;
         pending_q   <= 4'd0;
         last_make_q <= 2'd1;
         cur_dir_q   <= 2'd1;
         cmd_valid_q <= 1'b0;
         cmd_dir_q   <= 2'd1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         perr_q      <= perr_d;
         held_q      <= held_d;
         pending_q   <= pending_d;
         last_make_q <= last_make_d;
         cur_dir_q   <= cur_dir_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_dir_q   <= cmd_dir_d;
      end
   end

   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_dir   = cmd_dir_q;
   assign cur_dir       = cur_dir_q;
   assign held          = held_q;
   assign tick          = tick_q;
   assign protocol_err  = perr_q;

endmodule

// File: tb/tb_ps2_dir_scheduler.sv
// tb/tb_ps2_dir_scheduler.sv - scoreboard bench for ps2_dir_scheduler
module tb_ps2_dir_scheduler;

   localparam int TICK = 40;

   logic       clk;
   logic       resetn;
   logic [1:0] cur_dir;
   logic [3:0] held;
   logic       tick;
   logic       protocol_err;

   ps2_dir_scheduler_if bus ();

   ps2_dir_scheduler #(
      .TICK_CYCLES (TICK),
      .CNT_W       (6)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .bus          (bus.slave),
      .cur_dir      (cur_dir),
      .held         (held),
      .tick         (tick),
      .protocol_err (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         perr_pulses = 0;
   logic [1:0] exp_q[$];
   logic [1:0] exp_dir = 2'd1;
   logic       prev_valid = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: each new command pops the next expected direction,
   // and the direction must hold steady until it is acknowledged.
   always @(negedge clk) begin
      if (!resetn) begin
         prev_valid = 1'b0;
      end else begin
         if (protocol_err) perr_pulses++;
         if (bus.cmd_valid && !prev_valid) begin
            chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) exp_dir = exp_q.pop_front();
         end
         if (bus.cmd_valid) chk("cmd_dir", 32'(bus.cmd_dir), 32'(exp_dir));
         prev_valid = bus.cmd_valid;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.ps2_data        = b;
      bus.ps2_key_pressed = 1'b1;
      @(negedge clk);
      bus.ps2_key_pressed = 1'b0;
   endtask

   task automatic wait_tick(input string tag);
      int i;
      for (i = 0; i < 2 * TICK + 4; i++) begin
         @(negedge clk);
         if (tick) break;
      end
      if (i >= 2 * TICK + 4) chk({tag, "_tick_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic do_ack();
      @(negedge clk);
      bus.cmd_ack = 1'b1;
      @(negedge clk);
      bus.cmd_ack = 1'b0;
   endtask

   task automatic finish_cmd(input logic [1:0] d, input string tag);
      wait_tick(tag);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(bus.cmd_valid), 32'd1);
      do_ack();
      chk({tag, "_cur_dir"}, 32'(cur_dir), 32'(d));
      chk({tag, "_valid_clr"}, 32'(bus.cmd_valid), 32'd0);
   endtask

   task automatic step_cmd(input logic [1:0] d, input string tag);
      exp_q.push_back(d);
      finish_cmd(d, tag);
   endtask

   task automatic step_none(input string tag);
      wait_tick(tag);
      @(negedge clk);
      chk({tag, "_no_cmd"}, 32'(bus.cmd_valid), 32'd0);
   endtask

   initial begin
      resetn              = 1'b0;
      bus.ps2_data        = 8'h00;
      bus.ps2_key_pressed = 1'b0;
      bus.cmd_ack         = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
      chk("rst_cmd_dir", 32'(bus.cmd_dir), 32'd1);
      chk("rst_cur_dir", 32'(cur_dir), 32'd1);
      chk("rst_held", 32'(held), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_perr", 32'(protocol_err), 32'd0);
      resetn = 1'b1;

      // Extended up press, accepted and acknowledged
      wait_tick("align");
      send_byte(8'hE0);
      send_byte(8'h75);
      chk("held_up", 32'(held), 32'h1);
      step_cmd(2'd0, "ext_up");

      // Release up, turn right
      wait_tick("w1");
      send_byte(8'hF0);
      send_byte(8'h75);
      chk("held_rel", 32'(held), 32'h0);
      send_byte(8'h74);
      step_cmd(2'd1, "right");

      // Reversal to left is rejected and its pending bit is dropped
      wait_tick("w2");
      send_byte(8'hF0);
      send_byte(8'h74);
      send_byte(8'hE0);
      send_byte(8'h6B);
      chk("held_left", 32'(held), 32'h8);
      step_none("rev");
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h6B);
      chk("held_left_rel", 32'(held), 32'h0);
      step_none("rev_clr");

      // Down then up in one window: last make wins
      wait_tick("w3");
      send_byte(8'h72);
      send_byte(8'h75);
      step_cmd(2'd0, "last_make");
      wait_tick("w4");
      send_byte(8'hF0);
      send_byte(8'h72);
      send_byte(8'hF0);
      send_byte(8'h75);
      send_byte(8'h74);
      step_cmd(2'd1, "right2");

      // Up tapped and released, then down held: down is the last make
      wait_tick("w5");
      send_byte(8'hF0);
      send_byte(8'h74);
      send_byte(8'h75);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      send_byte(8'h72);
      step_cmd(2'd2, "tap_down");

      // Stall: unacked left across two ticks keeps pending up
      wait_tick("w6");
      send_byte(8'hF0);
      send_byte(8'h72);
      send_byte(8'h6B);
      exp_q.push_back(2'd3);
      wait_tick("stall_issue");
      @(negedge clk);
      chk("stall_valid", 32'(bus.cmd_valid), 32'd1);
      send_byte(8'h75);
      send_byte(8'hF0);
      send_byte(8'h75);
      wait_tick("stall1");
      wait_tick("stall2");
      @(negedge clk);
      chk("stall_still_valid", 32'(bus.cmd_valid), 32'd1);
      chk("stall_held", 32'(held), 32'h8);
      exp_q.push_back(2'd0);
      do_ack();
      chk("stall_cur_dir", 32'(cur_dir), 32'd3);
      finish_cmd(2'd0, "retained");
      send_byte(8'hF0);
      send_byte(8'h6B);

      // F0 F0 74: one protocol error, then 74 is a make
      wait_tick("w7");
      send_byte(8'hF0);
      send_byte(8'hF0);
      chk("perr_pulse", 32'(protocol_err), 32'd1);
      send_byte(8'h74);
      chk("perr_clear", 32'(protocol_err), 32'd0);
      chk("held_right", 32'(held), 32'h2);
      step_cmd(2'd1, "after_perr");

      // Async reset while a command is outstanding
      wait_tick("w8");
      send_byte(8'hF0);
      send_byte(8'h74);
      send_byte(8'h75);
      exp_q.push_back(2'd0);
      wait_tick("pre_rst");
      @(negedge clk);
      chk("pre_rst_valid", 32'(bus.cmd_valid), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.cmd_valid), 32'd0);
      chk("arst_cmd_dir", 32'(bus.cmd_dir), 32'd1);
      chk("arst_cur_dir", 32'(cur_dir), 32'd1);
      chk("arst_held", 32'(held), 32'd0);
      chk("arst_tick", 32'(tick), 32'd0);
      chk("arst_perr", 32'(protocol_err), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      step_none("post_rst");

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      chk("perr_count", 32'(perr_pulses), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
